// File: rtl/add_share_arbiter_pkg.sv
// add_share_pkg: shared constants, the clog2 helper and the response record
// used by the shared-adder arbiter and its users.
package add_share_pkg;

   localparam int DEF_DATAWIDTH = 8;
   localparam int DEF_NREQ      = 4;

   // Smallest n with 2**n >= value; a single requester still gets a 1-bit ID.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   typedef struct packed {
      logic [DEF_DATAWIDTH-1:0]   sum;
      logic [clog2(DEF_NREQ)-1:0] id;
      logic                       flag;
   } rsp_t;

endpackage

// File: rtl/add_share_arbiter_if.sv
// add_share_arbiter_if: requester-side operand bus plus the valid/ready
// response port of the shared adder.
interface add_share_arbiter_if
   import add_share_pkg::*;
#(
   parameter int DATAWIDTH = DEF_DATAWIDTH,
   parameter int NREQ      = DEF_NREQ,
   parameter int IDW       = clog2(NREQ)
);

   logic [NREQ-1:0]           req_valid;
   logic [NREQ*DATAWIDTH-1:0] req_a;
   logic [NREQ*DATAWIDTH-1:0] req_b;
   logic [NREQ-1:0]           req_ready;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DATAWIDTH-1:0]      rsp_sum;
   logic [IDW-1:0]            rsp_id;
   logic                      rsp_flag;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_id, rsp_flag
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_id, rsp_flag
   );

endinterface

// File: rtl/add_share_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant over NREQ requests; the pointer remembers the
// last winner and only moves when the grant is actually taken (advance).
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant_onehot,
   output logic [IDW-1:0]  grant_id
);

   logic [IDW-1:0] ptr;
   logic           found;
   int             idx;

   // Starting at NREQ-1 makes requester 0 the first one searched.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         ptr <= IDW'(NREQ - 1);
      end else if (advance) begin
         ptr <= grant_id;
      end
   end

   always_comb begin
      grant_onehot = '0;
      grant_id     = '0;
      found        = 1'b0;
      idx          = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found             = 1'b1;
            grant_id          = IDW'(idx);
            grant_onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: NREQ requesters share one adder through a round-robin
// arbiter and a one-entry result register. Define ADD_SAT_EN to saturate.
module add_share_arbiter
   import add_share_pkg::*;
#(
   parameter int DATAWIDTH = DEF_DATAWIDTH,
   parameter int NREQ      = DEF_NREQ,
   parameter int IDW       = clog2(NREQ)
) (
   input logic                Clk,
   input logic                Rst,
   add_share_arbiter_if.slave bus
);

   typedef struct packed {
      logic [DATAWIDTH-1:0] sum;
      logic [IDW-1:0]       id;
      logic                 flag;
   } result_t;

   logic [NREQ-1:0]      grant_onehot;
   logic [IDW-1:0]       grant_id;
   logic                 space;
   logic                 accept;
   logic [DATAWIDTH-1:0] op_a;
   logic [DATAWIDTH-1:0] op_b;
   logic [DATAWIDTH:0]   full_sum;
   result_t              result_next;
   result_t              result_q;
   logic                 valid_q;

   // A consumed result frees the register in the same cycle, so accepts never bubble.
   assign space  = !valid_q || bus.rsp_ready;
   assign accept = (|bus.req_valid) && space && Rst;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arbiter (
      .Clk          (Clk),
      .Rst          (Rst),
      .req          (bus.req_valid),
      .advance      (accept),
      .grant_onehot (grant_onehot),
      .grant_id     (grant_id)
   );

   always_comb begin
      result_next = '0;
      op_a        = bus.req_a[int'(grant_id)*DATAWIDTH +: DATAWIDTH];
      op_b        = bus.req_b[int'(grant_id)*DATAWIDTH +: DATAWIDTH];
      full_sum    = {1'b0, op_a} + {1'b0, op_b};
      result_next.id   = grant_id;
      result_next.flag = full_sum[DATAWIDTH];
`ifdef ADD_SAT_EN
      result_next.sum  = full_sum[DATAWIDTH] ? '1 : full_sum[DATAWIDTH-1:0];
`else
      result_next.sum  = full_sum[DATAWIDTH-1:0];
`endif
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         valid_q  <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         valid_q  <= 1'b1;
         result_q <= result_next;
      end else if (bus.rsp_ready) begin
         valid_q  <= 1'b0;
      end
   end

   assign bus.req_ready = accept ? grant_onehot : '0;
   assign bus.rsp_valid = valid_q;
   assign bus.rsp_sum   = result_q.sum;
   assign bus.rsp_id    = result_q.id;
   assign bus.rsp_flag  = result_q.flag;

endmodule

// File: tb/tb_add_share_arbiter.sv
// tb_add_share_arbiter: directed vectors with literal expectations plus a
// per-cycle behavioural model of arbitration, addition and the result register.
module tb_add_share_arbiter;
   import add_share_pkg::*;

   localparam int DW   = 8;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam logic [31:0] OPS_A = {8'd4, 8'd3, 8'd2, 8'd1};
   localparam logic [31:0] OPS_B = {8'd40, 8'd30, 8'd20, 8'd10};
`ifdef ADD_SAT_EN
   localparam int OVF_SUM = 255;
`else
   localparam int OVF_SUM = 44;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   add_share_arbiter_if #(.DATAWIDTH(DW), .NREQ(NREQ), .IDW(IDW)) bus ();

   add_share_arbiter #(.DATAWIDTH(DW), .NREQ(NREQ), .IDW(IDW)) dut (
      .Clk (clk),
      .Rst (rst_n),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] a, input logic [31:0] b, input logic ready);
      bus.req_valid = valid;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.rsp_ready = ready;
   endtask

   // Reference model: integer pointer, unsigned add, single held result.
   rsp_t m_rsp;
   bit   m_valid;
   int   m_ptr;
   int   waits [NREQ];

   always @(negedge clk) begin
      int  winner;
      int  a;
      int  b;
      int  full;
      int  exp_ready;
      bit  space;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_rsp   = '0;
         m_ptr   = NREQ - 1;
         foreach (waits[i]) waits[i] = 0;
         checkOutput("m_rst_req_ready", 32'(bus.req_ready), 0);
         checkOutput("m_rst_rsp_valid", 32'(bus.rsp_valid), 0);
         checkOutput("m_rst_rsp_sum", 32'(bus.rsp_sum), 0);
      end else begin
         checkOutput("m_rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
         checkOutput("m_rsp_sum", 32'(bus.rsp_sum), 32'(m_rsp.sum));
         checkOutput("m_rsp_id", 32'(bus.rsp_id), 32'(m_rsp.id));
         checkOutput("m_rsp_flag", 32'(bus.rsp_flag), 32'(m_rsp.flag));
         space  = !m_valid || bus.rsp_ready;
         winner = -1;
         if (space) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (winner < 0 && bus.req_valid[(m_ptr + k) % NREQ]) winner = (m_ptr + k) % NREQ;
            end
         end
         exp_ready = (winner >= 0) ? (1 << winner) : 0;
         checkOutput("m_req_ready", 32'(bus.req_ready), exp_ready);
         for (int i = 0; i < NREQ; i++) begin
            if (!bus.req_valid[i]) begin
               waits[i] = 0;
            end else if (bus.req_ready[i]) begin
               checkOutput("starvation", 32'(waits[i] <= NREQ - 1), 1);
               waits[i] = 0;
            end else if (|bus.req_ready) begin
               waits[i]++;
            end
         end
         if (winner >= 0) begin
            a    = int'(bus.req_a[winner*DW +: DW]);
            b    = int'(bus.req_b[winner*DW +: DW]);
            full = a + b;
            m_rsp.flag = (full > 255);
`ifdef ADD_SAT_EN
            m_rsp.sum  = (full > 255) ? 8'd255 : full[7:0];
`else
            m_rsp.sum  = full[7:0];
`endif
            m_rsp.id = winner[1:0];
            m_ptr    = winner;
            m_valid  = 1'b1;
         end else if (bus.rsp_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   initial begin
      int sums_exp [4];
      sums_exp = '{11, 22, 33, 44};
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      applyStimulus(4'b0000, 32'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(4'b1111, OPS_A, OPS_B, 1'b1);
      #2;
      checkOutput("reset_req_ready", 32'(bus.req_ready), 0);
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Round robin with everyone valid: grants 0,1,2,3,0 back to back.
      for (int k = 0; k < 5; k++) begin
         #2;
         checkOutput("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
         @(posedge clk);
         #1;
         checkOutput("rr_valid", 32'(bus.rsp_valid), 1);
         checkOutput("rr_id", 32'(bus.rsp_id), 32'(k % 4));
         checkOutput("rr_sum", 32'(bus.rsp_sum), 32'(sums_exp[k % 4]));
      end

      // Asynchronous reset with a result held.
      #1;
      checkOutput("pre_reset_valid", 32'(bus.rsp_valid), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", 32'(bus.rsp_valid), 0);
      checkOutput("async_rst_sum", 32'(bus.rsp_sum), 0);
      checkOutput("async_rst_id", 32'(bus.rsp_id), 0);
      checkOutput("async_rst_flag", 32'(bus.rsp_flag), 0);
      checkOutput("async_rst_ready", 32'(bus.req_ready), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #2;
      checkOutput("post_rst_grant", 32'(bus.req_ready), 32'h1);
      @(posedge clk);
      #1;
      checkOutput("post_rst_id", 32'(bus.rsp_id), 0);
      applyStimulus(4'b0000, OPS_A, OPS_B, 1'b1);
      repeat (2) @(posedge clk);
      #1;

      // Single request from requester 2.
      applyStimulus(4'b0100, 32'h0014_0000, 32'h0016_0000, 1'b1);
      #2;
      checkOutput("single_ready", 32'(bus.req_ready), 32'h4);
      @(posedge clk);
      #1;
      checkOutput("single_valid", 32'(bus.rsp_valid), 1);
      checkOutput("single_sum", 32'(bus.rsp_sum), 42);
      checkOutput("single_id", 32'(bus.rsp_id), 2);
      checkOutput("single_flag", 32'(bus.rsp_flag), 0);

      // Overflow behaviour, then the largest sum that does not carry.
      applyStimulus(4'b0001, 32'd200, 32'd100, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("ovf_sum", 32'(bus.rsp_sum), OVF_SUM);
      checkOutput("ovf_flag", 32'(bus.rsp_flag), 1);
      applyStimulus(4'b0001, 32'd255, 32'd0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("max_sum", 32'(bus.rsp_sum), 255);
      checkOutput("max_flag", 32'(bus.rsp_flag), 0);
      applyStimulus(4'b0000, OPS_A, OPS_B, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("drain_valid", 32'(bus.rsp_valid), 0);

      // Backpressure: pointer sits at 0, so requester 1 wins and then holds.
      applyStimulus(4'b1111, OPS_A, OPS_B, 1'b0);
      #2;
      checkOutput("bp_first_grant", 32'(bus.req_ready), 32'h2);
      @(posedge clk);
      #1;
      checkOutput("bp_sum", 32'(bus.rsp_sum), 22);
      for (int j = 0; j < 3; j++) begin
         #2;
         checkOutput("bp_ready_zero", 32'(bus.req_ready), 0);
         checkOutput("bp_sum_hold", 32'(bus.rsp_sum), 22);
         checkOutput("bp_id_hold", 32'(bus.rsp_id), 1);
         @(posedge clk);
         #1;
      end
      applyStimulus(4'b1111, OPS_A, OPS_B, 1'b1);
      #2;
      checkOutput("bp_release_grant", 32'(bus.req_ready), 32'h4);
      @(posedge clk);
      #1;
      checkOutput("bp_next_sum", 32'(bus.rsp_sum), 33);
      checkOutput("bp_next_id", 32'(bus.rsp_id), 2);
      applyStimulus(4'b0000, OPS_A, OPS_B, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("bp_drain_valid", 32'(bus.rsp_valid), 0);

      // Random traffic checked cycle by cycle by the model.
      for (int c = 0; c < 10000; c++) begin
         applyStimulus(4'($urandom_range(0, 15)), $urandom, $urandom, ($urandom_range(0, 3) != 0));
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
